mod_voice_allocator: RTL
========================

Name: mod_voice_allocator

Overview:
- Sits between `midi_receiver` (byte stream `dout`/`valid`) and the synthesis voice bank.
- Parses MIDI channel-voice messages, including running status, on one configured channel.
- Schedules NUM_VOICES oscillator voices on note-on/off: free-voice search, same-note retrigger, oldest-voice stealing.
- Presents registered per-voice gate/note/velocity to the oscillators.

Parameters:
- NUM_VOICES, 4, number of voices managed (2..16).
- MIDI_CHANNEL, 0, 4-bit channel accepted (0 = MIDI ch 1); other channels ignored.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- i_midi_byte  in  8  received MIDI byte
- i_midi_valid  in  1  1-cycle strobe, i_midi_byte valid
- o_voice_gate  out  NUM_VOICES  per-voice gate
- o_voice_note  out  NUM_VOICES x 7  per-voice note number
- o_voice_vel  out  NUM_VOICES x 7  per-voice velocity
- o_voice_update  out  1  1-cycle pulse when any voice field changed
- o_active_count  out  $clog2(NUM_VOICES+1)  number of gates high

Behaviour:
- Reset (async assert, sync deassert to i_clk):
  - all gates 0; notes 0; vels 0; o_voice_update 0; o_active_count 0.
  - Parser in IDLE; running status cleared; all voice ages 0.
- Parser FSM: IDLE -> DATA1 -> DATA2 -> (DATA1 via running status).
  - Status byte 0x80-0xEF: latch status. Next state is DATA1 if the channel matches and the type is 0x8/0x9/0xB; otherwise SKIP, which absorbs data bytes until the next status byte.
  - Data byte (bit7=0) in IDLE: ignored.
  - DATA1: latch d1 -> DATA2.
  - DATA2: message complete -> DATA1; running status is retained.
  - 0xF0-0xF7: clear running status -> IDLE. Sysex data bytes are ignored.
  - 0xF8-0xFF (real-time): ignored; no state change, even mid-message.
- Message decode:
  - 0x9n with vel>0 = NOTE_ON.
  - 0x9n with vel=0, or 0x8n = NOTE_OFF.
  - 0xBn with d1=123 = ALL_OFF: all gates cleared.
  - Other CCs ignored, except as described under Optional Feature.
- Allocation, applied in the cycle after DATA2 completes (1-cycle registered latency from the final byte strobe):
  - NOTE_ON, note already gated on voice k: update vel[k]; age[k]=0.
  - Else, if any gate=0: pick the lowest-index free voice.
  - Else steal: pick the voice with the maximum age; ties go to the lowest index.
  - Chosen voice: gate=1, note, vel, age=0. Every other voice with gate=1 increments its age, saturating at NUM_VOICES-1.
  - NOTE_OFF: clear the gate of the voice gated with a matching note. Note and vel are held for release. No match = no-op, and no update pulse.
- o_voice_update: pulses in the same cycle the registered outputs change.
- o_active_count: registered, consistent with the gates in the same cycle.
- Back-to-back messages: i_midi_valid can arrive every cycle. The allocation stage must accept one message per cycle with no loss.
- Status byte arriving in DATA2: aborts the partial message; the new status takes effect.

Optional Feature:
- Macro: FPGAUDIO_SUSTAIN_PEDAL_EN.
- Defined:
  - CC64 with value >=64 sets the internal pedal; <64 clears it.
  - While the pedal is set, NOTE_OFF marks the matching voice sustained (gate held) instead of clearing its gate.
  - Pedal release clears the gates of all sustained voices in one cycle, with one update pulse.
  - NOTE_ON retriggering a sustained note clears its sustained flag.
  - ALL_OFF also clears the pedal and all sustained flags.
- Undefined: CC64 ignored; no sustain state is synthesised.

Decomposition:
- Package pkg_midi:
  - status-nibble constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, CC=4'hB);
  - CC_SUSTAIN=7'd64 and CC_ALL_OFF=7'd123;
  - typedef midi_msg_t {type, d1[6:0], d2[6:0]};
  - typedef voice_t {gate, note[6:0], vel[6:0]}.
- Sub-module mod_midi_msg_parser: byte stream in, midi_msg_t plus 1-cycle msg_valid out; contains the parser FSM.
- mod_voice_allocator: instantiates the parser and holds the voice table, age logic and allocation.

Test Plan:
- Bytes 90 3C 64 -> voice0 gate=1, note=0x3C, vel=0x64; update pulse one cycle after the last byte; active_count=1.
- 90 3C 64 then running-status 3E 50, 40 00 -> voice1 note 0x3E, voice2 note 0x40 not allocated; third pair treated as note-off (vel 0) of 0x40 no-op, no pulse.
- NUM_VOICES=4: note-on 60,62,64,65, then 67 -> voice0 (oldest) stolen, note=67; then note-off 60 -> no-op.
- 90 3C 64, F8 inserted between every byte of 80 3C 00 -> voice0 gate cleared; F8 has no effect.
- Messages on channel 2 (91 3C 64) with MIDI_CHANNEL=0 -> no change; B0 7B 00 with 3 voices on -> all gates 0, active_count=0.
- Reset asserted mid-message (after 90 3C), then 64 -> no allocation; outputs remain at reset values.

Source files
------------

// File: rtl/pkg_midi.sv
// Shared MIDI constants and message/voice types for the voice allocator slice.
package pkg_midi;

  localparam logic [3:0] NOTE_OFF   = 4'h8;
  localparam logic [3:0] NOTE_ON    = 4'h9;
  localparam logic [3:0] CC         = 4'hB;
  localparam logic [6:0] CC_SUSTAIN = 7'd64;
  localparam logic [6:0] CC_ALL_OFF = 7'd123;

  typedef struct packed {
    logic [3:0] msg_type;
    logic [6:0] d1;
    logic [6:0] d2;
  } midi_msg_t;

  typedef struct packed {
    logic       gate;
    logic [6:0] note;
    logic [6:0] vel;
  } voice_t;

endpackage

// File: rtl/mod_midi_msg_parser.sv
// MIDI byte-stream parser with running status for one channel; emits a complete
// channel-voice message as a 1-cycle strobe in the same cycle as its last data byte.
module mod_midi_msg_parser
  import pkg_midi::*;
#(
  parameter logic [3:0] MIDI_CHANNEL = 4'd0
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic [7:0] i_midi_byte,
  input  logic      i_midi_valid,
  output midi_msg_t o_msg,
  output logic      o_msg_valid
);

  typedef enum logic [1:0] {StIdle, StData1, StData2, StSkip} state_e;

  state_e     state_q, state_d;
  logic [3:0] type_q, type_d;
  logic [6:0] d1_q, d1_d;
  logic       accept;

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    d1_d        = d1_q;
    o_msg_valid = 1'b0;
    o_msg       = '{msg_type: type_q, d1: d1_q, d2: i_midi_byte[6:0]};
    accept      = (i_midi_byte[3:0] == MIDI_CHANNEL) &&
                  (i_midi_byte[7:4] inside {NOTE_OFF, NOTE_ON, CC});
    // Real-time bytes (F8-FF) pass through without touching any state.
    if (i_midi_valid && (i_midi_byte[7:3] != 5'b11111)) begin
      if (i_midi_byte[7:4] == 4'hF) begin
        type_d  = 4'h0;
        state_d = StIdle;
      end else if (i_midi_byte[7]) begin
        type_d  = i_midi_byte[7:4];
        state_d = accept ? StData1 : StSkip;
      end else begin
        case (state_q)
          StData1: begin
            d1_d    = i_midi_byte[6:0];
            state_d = StData2;
          end
          StData2: begin
            o_msg_valid = 1'b1;
            state_d     = StData1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      type_q  <= 4'h0;
      d1_q    <= 7'd0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      d1_q    <= d1_d;
    end
  end

endmodule

// File: rtl/mod_voice_allocator.sv
// Polyphonic voice allocator: free-voice search, same-note retrigger, oldest-voice steal.
// Optional sustain pedal (CC64) enabled by defining FPGAUDIO_SUSTAIN_PEDAL_EN.
module mod_voice_allocator
  import pkg_midi::*;
#(
  parameter int unsigned NUM_VOICES   = 4,
  parameter logic [3:0]  MIDI_CHANNEL = 4'd0
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [7:0]                        i_midi_byte,
  input  logic                              i_midi_valid,
  output logic [NUM_VOICES-1:0]             o_voice_gate,
  output logic [NUM_VOICES-1:0][6:0]        o_voice_note,
  output logic [NUM_VOICES-1:0][6:0]        o_voice_vel,
  output logic                              o_voice_update,
  output logic [$clog2(NUM_VOICES+1)-1:0]   o_active_count
);

  localparam int unsigned IdxW = $clog2(NUM_VOICES);
  localparam int unsigned CntW = $clog2(NUM_VOICES + 1);
  localparam logic [IdxW-1:0] AgeMax = IdxW'(NUM_VOICES - 1);

  midi_msg_t msg;
  logic      msg_valid;

  mod_midi_msg_parser #(
    .MIDI_CHANNEL (MIDI_CHANNEL)
  ) u_parser (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_midi_byte  (i_midi_byte),
    .i_midi_valid (i_midi_valid),
    .o_msg        (msg),
    .o_msg_valid  (msg_valid)
  );

  voice_t [NUM_VOICES-1:0] voice_q, voice_d;
  logic [NUM_VOICES-1:0][IdxW-1:0] age_q, age_d;
  logic            update_q;
  logic [CntW-1:0] active_q, active_d;

  logic            is_on, is_off, is_all_off;
  logic            hit_found, free_found;
  logic [IdxW-1:0] hit_idx, free_idx, old_idx, chosen, old_age;

`ifdef FPGAUDIO_SUSTAIN_PEDAL_EN
  logic                  pedal_q, pedal_d;
  logic [NUM_VOICES-1:0] sus_q, sus_d;
`endif

  always_comb begin
    is_on      = (msg.msg_type == NOTE_ON) && (msg.d2 != 7'd0);
    is_off     = (msg.msg_type == NOTE_OFF) || ((msg.msg_type == NOTE_ON) && (msg.d2 == 7'd0));
    is_all_off = (msg.msg_type == CC) && (msg.d1 == CC_ALL_OFF);

    // Descending scans so the lowest qualifying index wins; >= gives age ties to low index.
    hit_found  = 1'b0;
    free_found = 1'b0;
    hit_idx    = '0;
    free_idx   = '0;
    old_idx    = '0;
    old_age    = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (voice_q[i].gate && (voice_q[i].note == msg.d1)) begin
        hit_found = 1'b1;
        hit_idx   = IdxW'(i);
      end
      if (!voice_q[i].gate) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
      if (age_q[i] >= old_age) begin
        old_age = age_q[i];
        old_idx = IdxW'(i);
      end
    end
    chosen = hit_found ? hit_idx : (free_found ? free_idx : old_idx);
  end

  always_comb begin
    voice_d = voice_q;
    age_d   = age_q;
`ifdef FPGAUDIO_SUSTAIN_PEDAL_EN
    pedal_d = pedal_q;
    sus_d   = sus_q;
`endif
    if (msg_valid) begin
      if (is_on) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (voice_q[i].gate && (IdxW'(i) != chosen) && (age_q[i] != AgeMax)) begin
            age_d[i] = age_q[i] + 1'b1;
          end
        end
        voice_d[chosen] = '{gate: 1'b1, note: msg.d1, vel: msg.d2};
        age_d[chosen]   = '0;
`ifdef FPGAUDIO_SUSTAIN_PEDAL_EN
        sus_d[chosen]   = 1'b0;
`endif
      end else if (is_off) begin
        if (hit_found) begin
`ifdef FPGAUDIO_SUSTAIN_PEDAL_EN
          if (pedal_q) sus_d[hit_idx] = 1'b1;
          else         voice_d[hit_idx].gate = 1'b0;
`else
          voice_d[hit_idx].gate = 1'b0;
`endif
        end
      end else if (is_all_off) begin
        for (int i = 0; i < NUM_VOICES; i++) voice_d[i].gate = 1'b0;
`ifdef FPGAUDIO_SUSTAIN_PEDAL_EN
        pedal_d = 1'b0;
        sus_d   = '0;
`endif
      end
`ifdef FPGAUDIO_SUSTAIN_PEDAL_EN
      else if ((msg.msg_type == CC) && (msg.d1 == CC_SUSTAIN)) begin
        pedal_d = msg.d2[6];
        if (pedal_q && !msg.d2[6]) begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (sus_q[i]) voice_d[i].gate = 1'b0;
          end
          sus_d = '0;
        end
      end
`endif
    end

    active_d = '0;
    for (int i = 0; i < NUM_VOICES; i++) active_d = active_d + CntW'(voice_d[i].gate);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      voice_q  <= '0;
      age_q    <= '0;
      update_q <= 1'b0;
      active_q <= '0;
    end else begin
      voice_q  <= voice_d;
      age_q    <= age_d;
      update_q <= (voice_d != voice_q);
      active_q <= active_d;
    end
  end

`ifdef FPGAUDIO_SUSTAIN_PEDAL_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pedal_q <= 1'b0;
      sus_q   <= '0;
    end else begin
      pedal_q <= pedal_d;
      sus_q   <= sus_d;
    end
  end
`endif

  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      o_voice_gate[i] = voice_q[i].gate;
      o_voice_note[i] = voice_q[i].note;
      o_voice_vel[i]  = voice_q[i].vel;
    end
  end

  assign o_voice_update = update_q;
  assign o_active_count = active_q;

endmodule
